// File: rtl/mult_regfile_seq.sv
// mult_regfile_seq: register file with an iterative shift-add multiplier,
// driven by a four-phase req/ack handshake (LOAD, MUL, READ, MAC).
//
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   req / ack       four-phase handshake (req may be asynchronous)
//   op              00 LOAD, 01 MUL, 10 READ, 11 MAC
//   rd, rm, rs      destination, operand A / READ source, operand B
//   wdata / rdata   LOAD data in, READ data out
//   busy            high whenever the FSM is not idle
//   ovf             multiply overflow flag
//
// Build option: define MULT_OVF_EN to keep the full 2N-bit product and
// drive ovf; otherwise the accumulator is N bits and ovf is tied low.
module mult_regfile_seq #(
  parameter int N      = 32,
  parameter int REG_AW = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req,
  output logic              ack,
  input  logic [1:0]        op,
  input  logic [REG_AW-1:0] rd,
  input  logic [REG_AW-1:0] rm,
  input  logic [REG_AW-1:0] rs,
  input  logic [N-1:0]      wdata,
  output logic [N-1:0]      rdata,
  output logic              busy,
  output logic              ovf
);

  localparam int NR = 2**REG_AW;
  localparam int CW = $clog2(N+1);
`ifdef MULT_OVF_EN
  localparam int PW = 2*N;
`else
  localparam int PW = N;
`endif

  localparam logic [1:0] OP_LOAD = 2'b00;
  localparam logic [1:0] OP_MUL  = 2'b01;
  localparam logic [1:0] OP_READ = 2'b10;
  localparam logic [1:0] OP_MAC  = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_MUL,
    S_WB,
    S_ACK
  } state_t;

  state_t r_st;
  state_t w_nxt;

  logic              r_sync1;
  logic              r_req_s;
  logic [1:0]        r_op;
  logic [REG_AW-1:0] r_rd;
  logic [N-1:0]      r_wd;
  logic [PW-1:0]     r_a;
  logic [N-1:0]      r_b;
  logic [N-1:0]      r_c;
  logic [PW-1:0]     r_acc;
  logic [CW-1:0]     r_cnt;
  logic [N-1:0]      r_rdata;
  logic [N-1:0]      r_regs [NR];

  logic [N-1:0]      w_lo;
  logic [N-1:0]      w_mac;

  assign w_lo  = r_acc[N-1:0];
  assign w_mac = r_c + w_lo;
  assign rdata = r_rdata;

`ifdef MULT_OVF_EN
  logic r_ovf;
  logic w_cy;
  // An N-bit add carried out iff the wrapped sum is below an addend.
  assign w_cy = (w_mac < r_c);
  assign ovf  = r_ovf;
`else
  assign ovf  = 1'b0;
`endif

  // Two-flop synchroniser for the asynchronous request.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= 1'b0;
      r_req_s <= 1'b0;
    end else begin
      r_sync1 <= req;
      r_req_s <= r_sync1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_st <= S_IDLE;
    else        r_st <= w_nxt;
  end

  always_comb begin
    w_nxt = r_st;
    unique case (r_st)
      S_IDLE:  if (r_req_s) w_nxt = S_FETCH;
      // op[0] selects the multiplying commands (MUL, MAC).
      S_FETCH: w_nxt = op[0] ? S_MUL : S_WB;
      S_MUL:   if (r_cnt == CW'(1)) w_nxt = S_WB;
      S_WB:    w_nxt = S_ACK;
      S_ACK:   if (!r_req_s) w_nxt = S_IDLE;
      default: w_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    ack  = (r_st == S_ACK);
    busy = (r_st != S_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_op    <= '0;
      r_rd    <= '0;
      r_wd    <= '0;
      r_a     <= '0;
      r_b     <= '0;
      r_c     <= '0;
      r_acc   <= '0;
      r_cnt   <= '0;
      r_rdata <= '0;
`ifdef MULT_OVF_EN
      r_ovf   <= 1'b0;
`endif
      for (int i = 0; i < NR; i++) r_regs[i] <= '0;
    end else begin
      case (r_st)
        S_FETCH: begin
          r_op  <= op;
          r_rd  <= rd;
          r_wd  <= wdata;
          r_a   <= PW'(r_regs[rm]);
          r_b   <= r_regs[rs];
          r_c   <= r_regs[rd];
          r_acc <= '0;
          r_cnt <= CW'(N);
        end
        S_MUL: begin
          if (r_b[0]) r_acc <= r_acc + r_a;
          r_a   <= r_a << 1;
          r_b   <= r_b >> 1;
          r_cnt <= r_cnt - CW'(1);
        end
        S_WB: begin
          case (r_op)
            OP_LOAD: r_regs[r_rd] <= r_wd;
            OP_READ: r_rdata <= r_a[N-1:0];
            OP_MUL: begin
              r_regs[r_rd] <= w_lo;
`ifdef MULT_OVF_EN
              r_ovf <= |r_acc[PW-1:N];
`endif
            end
            OP_MAC: begin
              r_regs[r_rd] <= w_mac;
`ifdef MULT_OVF_EN
              r_ovf <= (|r_acc[PW-1:N]) | w_cy;
`endif
            end
            default: ;
          endcase
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mult_regfile_seq.sv
// tb_mult_regfile_seq: scoreboard bench for mult_regfile_seq.
// Reference model computes results with plain 64-bit arithmetic.
module tb_mult_regfile_seq;

  localparam int N = 32;
  localparam logic [1:0] LOAD = 2'b00;
  localparam logic [1:0] MUL  = 2'b01;
  localparam logic [1:0] READ = 2'b10;
  localparam logic [1:0] MAC  = 2'b11;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req = 1'b0;
  logic        ack;
  logic [1:0]  op = '0;
  logic [3:0]  rd = '0;
  logic [3:0]  rm = '0;
  logic [3:0]  rs = '0;
  logic [31:0] wdata = '0;
  logic [31:0] rdata;
  logic        busy;
  logic        ovf;

  mult_regfile_seq #(.N(N), .REG_AW(4)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .ack(ack),
    .op(op), .rd(rd), .rm(rm), .rs(rs),
    .wdata(wdata), .rdata(rdata), .busy(busy), .ovf(ovf)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] rdata;
    logic        ovf;
  } exp_t;

  exp_t        q[$];
  logic [31:0] m_r [16];
  logic [31:0] m_rd;
  logic        m_ovf;
  int          checks = 0;
  int          errors = 0;
  logic        prev_ack = 1'b0;

  task automatic check(input string nm, input logic [63:0] act,
                       input logic [63:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, expv);
    end
  endtask

  function automatic logic ovf_en();
`ifdef MULT_OVF_EN
    return 1'b1;
`else
    return 1'b0;
`endif
  endfunction

  task automatic model(input logic [1:0] o, input int d, input int m,
                       input int s, input logic [31:0] w);
    logic [63:0] p;
    logic [32:0] sum;
    logic [31:0] a, b, c;
    a = m_r[m];
    b = m_r[s];
    c = m_r[d];
    p = {32'b0, a} * {32'b0, b};
    case (o)
      LOAD: m_r[d] = w;
      READ: m_rd = a;
      MUL: begin
        m_r[d] = p[31:0];
        if (ovf_en()) m_ovf = (p[63:32] != 0);
      end
      default: begin
        sum = {1'b0, c} + {1'b0, p[31:0]};
        m_r[d] = sum[31:0];
        if (ovf_en()) m_ovf = (p[63:32] != 0) || sum[32];
      end
    endcase
    q.push_back('{rdata: m_rd, ovf: m_ovf});
  endtask

  task automatic model_reset();
    for (int i = 0; i < 16; i++) m_r[i] = '0;
    m_rd  = '0;
    m_ovf = 1'b0;
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (rst_n && ack && !prev_ack) begin
      if (q.size() == 0) begin
        check("unexpected_ack", 1, 0);
      end else begin
        e = q.pop_front();
        check("rdata", rdata, e.rdata);
        check("ovf", ovf, e.ovf);
      end
    end
    prev_ack = ack;
  end

  task automatic drive(input logic [1:0] o, input int d, input int m,
                       input int s, input logic [31:0] w);
    op    = o;
    rd    = d[3:0];
    rm    = m[3:0];
    rs    = s[3:0];
    wdata = w;
  endtask

  task automatic txn(input logic [1:0] o, input int d, input int m,
                     input int s, input logic [31:0] w, input int hold);
    int cnt;
    int lat;
    logic held;
    model(o, d, m, s, w);
    @(posedge clk);
    #2;
    drive(o, d, m, s, w);
    req = 1'b1;
    cnt = 0;
    while (cnt < 200) begin
      @(posedge clk);
      cnt++;
      #1;
      if (ack) break;
    end
    lat = o[0] ? N + 5 : 5;
    check("ack_latency", cnt, lat);
    check("busy_at_ack", busy, 1);
    held = 1'b1;
    repeat (hold) begin
      @(posedge clk);
      #1;
      if (!ack) held = 1'b0;
    end
    if (hold > 0) check("ack_held", held, 1);
    req = 1'b0;
    cnt = 0;
    while (cnt < 20) begin
      @(posedge clk);
      cnt++;
      #1;
      if (!ack) break;
    end
    check("ack_drop", cnt, 3);
  endtask

  initial begin
    int cnt;
    int highs;
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_ack", ack, 0);
    check("rst_busy", busy, 0);
    check("rst_rdata", rdata, 0);
    check("rst_ovf", ovf, 0);
    #2 rst_n = 1'b1;

    txn(LOAD, 3, 0, 0, 32'h7, 0);
    txn(LOAD, 4, 0, 0, 32'h6, 0);
    txn(MUL, 5, 3, 4, 0, 0);
    txn(READ, 0, 5, 0, 0, 0);
    txn(MAC, 5, 3, 4, 0, 0);
    txn(READ, 0, 5, 0, 0, 0);
    txn(MUL, 3, 3, 3, 0, 0);
    txn(READ, 0, 3, 0, 0, 0);
    txn(LOAD, 1, 0, 0, 32'hFFFF_FFFF, 0);
    txn(LOAD, 2, 0, 0, 32'h2, 0);
    txn(MUL, 6, 1, 2, 0, 0);
    txn(READ, 0, 6, 0, 0, 0);

    // Reset ten cycles into a MUL targeting r5.
    @(posedge clk);
    #2;
    drive(MUL, 5, 3, 4, 0);
    req = 1'b1;
    repeat (12) @(posedge clk);
    #2;
    check("busy_in_mul", busy, 1);
    rst_n = 1'b0;
    #1;
    check("rst_mid_ack", ack, 0);
    check("rst_mid_busy", busy, 0);
    model_reset();
    req = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;
    txn(READ, 0, 5, 0, 0, 0);

    // Hold req after ack; no second command may run.
    txn(LOAD, 7, 0, 0, 32'hA5A5_0001, 20);
    txn(LOAD, 8, 0, 0, 32'h0000_0003, 0);
    txn(MAC, 7, 8, 8, 0, 0);
    txn(READ, 0, 7, 0, 0, 0);

    // Early req drop: command completes, ack pulses one cycle.
    model(MUL, 9, 7, 8, 0);
    @(posedge clk);
    #2;
    drive(MUL, 9, 7, 8, 0);
    req = 1'b1;
    repeat (4) @(posedge clk);
    #2 req = 1'b0;
    highs = 0;
    repeat (60) begin
      @(posedge clk);
      #1;
      if (ack) highs++;
    end
    check("early_ack_pulse", highs, 1);
    check("early_busy_idle", busy, 0);
    txn(READ, 0, 9, 0, 0, 0);

    for (int i = 0; i < 30; i++) begin
      logic [1:0]  o;
      logic [31:0] w;
      o = 2'($urandom_range(0, 3));
      w = $urandom_range(0, 1) ? $urandom : 32'($urandom_range(0, 65535));
      txn(o, $urandom_range(0, 15), $urandom_range(0, 15),
          $urandom_range(0, 15), w, 0);
    end

    cnt = 0;
    while (q.size() != 0 && cnt < 100) begin
      @(posedge clk);
      cnt++;
    end
    check("queue_drain", q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
